alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit ALU control code produced by the control path's ALU decoder and returns a registered result plus a zero flag for branch resolution.
- Single-cycle ops finish in 1 cycle. Shifts run on an iterative 1-bit-per-cycle shifter to save area.
- Valid/ready handshakes on both sides let the multi-cycle core stall fetch/decode while a shift is in progress.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- SHW, $clog2(XLEN) = 5, shift-amount width. Derived; do not override.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  operation request valid
- o_ready  output  1  unit can accept an operation this cycle
- i_ALUCtrl  input  4  operation code (encoding below)
- i_srcA  input  XLEN  operand A
- i_srcB  input  XLEN  operand B; for shifts only [SHW-1:0] is used
- i_flush  input  1  synchronous abort of any in-flight operation
- o_valid  output  1  result valid
- i_result_ready  input  1  consumer takes the result
- o_result  output  XLEN  registered result
- o_zero  output  1  o_result == 0, registered together with o_result
- o_illegal  output  1  result came from an unsupported code

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (i_clk, i_rst_n).
- Codes:
  - 0000 add; 0001 sub; 0010 or; 0011 and; 0100 xor.
  - 0101 sra; 0110 srl; 0111 sll.
  - 1101 slt (signed); 1110 sltu (unsigned). slt/sltu produce a zero-extended 1 or 0.
  - Any other code: o_result = 0, o_illegal = 1, 1-cycle latency.
- Arithmetic: add/sub wrap modulo 2^XLEN with no overflow flag. sra replicates bit XLEN-1.
- FSM states: IDLE, SHIFT, DONE.
- Reset: state = IDLE; o_valid = 0, o_result = 0, o_zero = 0, o_illegal = 0, shift counter = 0.
- o_ready = 1 only in IDLE. There is no accept in DONE, so peak throughput is one op every 2 cycles.
- IDLE, when i_valid & o_ready at a clock edge:
  - Non-shift op: compute combinationally, register o_result, o_zero and o_illegal, go to DONE. o_valid is high in the next cycle (latency 1).
  - Shift with shamt = 0: register o_result = i_srcA, go to DONE (latency 1).
  - Shift with shamt = n > 0: load accumulator = i_srcA, counter = n, latch the shift type, go to SHIFT.
- SHIFT, each edge:
  - Shift the accumulator by 1 in the latched direction/type and decrement the counter.
  - On the edge where the counter goes 1 -> 0, write the shifted value to o_result/o_zero and go to DONE.
  - Total latency is 1 + n edges from acceptance to o_valid; shamt 31 gives 32 edges.
- DONE:
  - o_valid = 1, and o_result/o_zero/o_illegal hold stable until i_result_ready.
  - On an edge with i_result_ready, go to IDLE with o_valid = 0. o_result keeps its last value.
- Operand capture: operands are sampled only at acceptance. Changes to i_srcA, i_srcB or i_ALUCtrl afterwards have no effect.
- i_flush has priority over all other events. On the next edge: state = IDLE, o_valid = 0, counter = 0, and o_result is unchanged. Flush in IDLE with i_valid high: the request is not accepted.
- Reset mid-operation (SHIFT or DONE): returns immediately to reset values and the result is lost.
- i_valid while not ready: ignored. The requester must hold it until o_ready.

Decomposition:
- Shared package alu_pkg holds:
  - the ALU control code localparams (ALU_ADD = 4'b0000 … ALU_SLTU = 4'b1110), which the decoder also uses;
  - the FSM state encoding;
  - an is_shift(code) helper function.
- Sub-module alu_comb: purely combinational single-cycle ops (add/sub/logic/slt/sltu/illegal detect). The FSM, iterative shifter and output registers stay in alu_exec_unit.

Test Plan:
- Reset, then add A=0x7FFFFFFF, B=1 -> o_valid one cycle after accept, o_result = 0x80000000, o_zero = 0. Then sub A=5, B=5 -> o_result = 0, o_zero = 1.
- slt A=0xFFFFFFFF, B=1 -> 1; sltu with the same operands -> 0. Code 1111 -> o_result = 0, o_illegal = 1, latency 1.
- sra A=0x80000000, B=31 -> o_valid exactly 32 edges after accept, o_result = 0xFFFFFFFF. srl with the same operands -> 0x00000001. sll A=1, B=0x20 (shamt 0) -> 0x00000001 at latency 1.
- Backpressure: hold i_result_ready = 0 for 5 cycles in DONE -> o_valid and o_result stable, o_ready = 0, and new i_valid is ignored. Release -> IDLE, then the next op is accepted.
- Flush in SHIFT (sll A=3, B=10) after 4 cycles -> IDLE on the next edge, o_valid never asserts, and a following xor 0xF0 ^ 0xFF gives 0x0F.
- Deassert i_rst_n asynchronously mid-SHIFT -> all outputs 0 immediately with no clock edge. After release, o_ready = 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes (also used by the ALU decoder),
// execute-unit FSM encoding and the shift-op classifier.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRA  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1101;
  localparam logic [3:0] ALU_SLTU = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SRA) || (code == ALU_SRL) || (code == ALU_SLL);
  endfunction

endpackage

// File: rtl/alu_exec_unit_comb.sv
// Single-cycle ALU operations. Shift codes return 0 here; the execute unit
// routes them to its iterative shifter instead.
module alu_comb
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      i_ctrl,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result,
  output logic            o_illegal
);

  always_comb begin
    o_result  = '0;
    o_illegal = 1'b0;
    case (i_ctrl)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_AND:  o_result = i_a & i_b;
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      ALU_SRA, ALU_SRL, ALU_SLL: o_result = '0;
      default:  o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops via alu_comb, shifts on a 1-bit-per-cycle
// iterative shifter, registered result with valid/ready handshakes on both sides.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [3:0]      i_ALUCtrl,
  input  logic [XLEN-1:0] i_srcA,
  input  logic [XLEN-1:0] i_srcB,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_result_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero,
  output logic            o_illegal
);

  localparam int SHW = $clog2(XLEN);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [3:0]        sh_op_q, sh_op_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic              illegal_q, illegal_d;
  logic              valid_q, valid_d;

  logic [XLEN-1:0]   comb_result;
  logic              comb_illegal;
  logic [XLEN-1:0]   acc_step;
  logic [SHW-1:0]    shamt;

  alu_comb #(.XLEN(XLEN)) u_comb (
    .i_ctrl    (i_ALUCtrl),
    .i_a       (i_srcA),
    .i_b       (i_srcB),
    .o_result  (comb_result),
    .o_illegal (comb_illegal)
  );

  assign shamt = i_srcB[SHW-1:0];

  always_comb begin
    case (sh_op_q)
      ALU_SRA: acc_step = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
      ALU_SRL: acc_step = {1'b0, acc_q[XLEN-1:1]};
      default: acc_step = {acc_q[XLEN-2:0], 1'b0};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sh_op_d   = sh_op_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;

    // Flush wins over acceptance, shifting and result hand-off alike.
    if (i_flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            if (is_shift(i_ALUCtrl) && (shamt != '0)) begin
              acc_d   = i_srcA;
              cnt_d   = shamt;
              sh_op_d = i_ALUCtrl;
              state_d = ST_SHIFT;
            end else if (is_shift(i_ALUCtrl)) begin
              result_d  = i_srcA;
              zero_d    = (i_srcA == '0);
              illegal_d = 1'b0;
              state_d   = ST_DONE;
            end else begin
              result_d  = comb_result;
              zero_d    = (comb_result == '0);
              illegal_d = comb_illegal;
              state_d   = ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          acc_d = acc_step;
          cnt_d = cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            result_d  = acc_step;
            zero_d    = (acc_step == '0);
            illegal_d = 1'b0;
            state_d   = ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_result_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      sh_op_q   <= ALU_SLL;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sh_op_q   <= sh_op_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      valid_q   <= valid_d;
    end
  end

  assign o_ready   = (state_q == ST_IDLE);
  assign o_valid   = valid_q;
  assign o_result  = result_q;
  assign o_zero    = zero_q;
  assign o_illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [3:0]  i_ALUCtrl = 4'h0;
  logic [31:0] i_srcA = '0;
  logic [31:0] i_srcB = '0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_result_ready = 1'b0;
  logic [31:0] o_result;
  logic        o_zero;
  logic        o_illegal;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 i_clk = ~i_clk;

  alu_exec_unit dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_ALUCtrl      (i_ALUCtrl),
    .i_srcA         (i_srcA),
    .i_srcB         (i_srcB),
    .i_flush        (i_flush),
    .o_valid        (o_valid),
    .i_result_ready (i_result_ready),
    .o_result       (o_result),
    .o_zero         (o_zero),
    .o_illegal      (o_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Accept one op, scramble inputs after acceptance, time the latency,
  // check the result fields, then hand the result off.
  task automatic run_op(input string tag, input logic [3:0] code,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_zero,
                        input logic exp_ill, input int exp_lat);
    int lat;
    @(negedge i_clk);
    check({tag, " ready"}, 32'(o_ready), 32'd1);
    i_valid = 1'b1; i_ALUCtrl = code; i_srcA = a; i_srcB = b;
    @(posedge i_clk);
    lat = 1;
    @(negedge i_clk);
    i_valid = 1'b0; i_ALUCtrl = ~code; i_srcA = ~a; i_srcB = ~b;
    while (!o_valid && lat < 100) begin
      @(posedge i_clk);
      lat++;
      @(negedge i_clk);
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, o_result, exp_res);
    check({tag, " zero"}, 32'(o_zero), 32'(exp_zero));
    check({tag, " illegal"}, 32'(o_illegal), 32'(exp_ill));
    i_result_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_result_ready = 1'b0;
    check({tag, " valid_drop"}, 32'(o_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] held;

    #2;
    check("reset valid", 32'(o_valid), 32'd0);
    check("reset result", o_result, 32'd0);
    check("reset zero", 32'(o_zero), 32'd0);
    check("reset illegal", 32'(o_illegal), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    run_op("add",   4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b0, 1);
    run_op("sub",   4'b0001, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0, 1);
    run_op("or",    4'b0010, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, 1);
    run_op("and",   4'b0011, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1'b0, 1);
    run_op("slt",   4'b1101, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1);
    run_op("sltu",  4'b1110, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1);
    run_op("ill",   4'b1111, 32'h1234_5678, 32'h1, 32'h0, 1'b1, 1'b1, 1);
    run_op("ill8",  4'b1000, 32'h1, 32'h1, 32'h0, 1'b1, 1'b1, 1);
    run_op("sra31", 4'b0101, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 32);
    run_op("srl31", 4'b0110, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 1'b0, 32);
    run_op("sll0",  4'b0111, 32'h1, 32'h20, 32'h0000_0001, 1'b0, 1'b0, 1);
    run_op("sll4",  4'b0111, 32'h8000_0001, 32'd4, 32'h0000_0010, 1'b0, 1'b0, 5);
    run_op("srl1z", 4'b0110, 32'h1, 32'd1, 32'h0, 1'b1, 1'b0, 2);

    // Backpressure: result must hold in DONE while new requests are ignored.
    @(negedge i_clk);
    i_valid = 1'b1; i_ALUCtrl = 4'b0000; i_srcA = 32'd100; i_srcB = 32'd23;
    @(posedge i_clk);
    @(negedge i_clk);
    i_ALUCtrl = 4'b0001; i_srcA = 32'd1; i_srcB = 32'd1;
    for (int c = 0; c < 5; c++) begin
      check("bp valid", 32'(o_valid), 32'd1);
      check("bp result", o_result, 32'd123);
      check("bp ready", 32'(o_ready), 32'd0);
      @(posedge i_clk);
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    i_result_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_result_ready = 1'b0;
    check("bp release ready", 32'(o_ready), 32'd1);
    check("bp release valid", 32'(o_valid), 32'd0);
    check("bp result kept", o_result, 32'd123);
    run_op("bp next", 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);

    // Flush mid-shift: never a result, result register untouched.
    @(negedge i_clk);
    i_valid = 1'b1; i_ALUCtrl = 4'b0111; i_srcA = 32'd3; i_srcB = 32'd10;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("flush no valid", 32'(o_valid), 32'd0);
      @(posedge i_clk);
      @(negedge i_clk);
    end
    i_flush = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_flush = 1'b0;
    check("flush ready", 32'(o_ready), 32'd1);
    check("flush valid", 32'(o_valid), 32'd0);
    check("flush result", o_result, 32'd5);
    for (int c = 0; c < 12; c++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      check("flush stays idle", 32'(o_valid), 32'd0);
    end
    run_op("xor", 4'b0100, 32'hF0, 32'hFF, 32'h0F, 1'b0, 1'b0, 1);

    // Flush in IDLE blocks acceptance.
    @(negedge i_clk);
    i_valid = 1'b1; i_flush = 1'b1; i_ALUCtrl = 4'b0000; i_srcA = 32'd7; i_srcB = 32'd7;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0; i_flush = 1'b0;
    check("idle flush ready", 32'(o_ready), 32'd1);
    @(posedge i_clk);
    @(negedge i_clk);
    check("idle flush valid", 32'(o_valid), 32'd0);
    check("idle flush result", o_result, 32'h0F);

    // Asynchronous reset during a shift.
    i_valid = 1'b1; i_ALUCtrl = 4'b0101; i_srcA = 32'h8000_0000; i_srcB = 32'd20;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    held = o_result;
    check("pre-reset result", held, 32'h0F);
    #2 i_rst_n = 1'b0;
    #1;
    check("arst valid", 32'(o_valid), 32'd0);
    check("arst result", o_result, 32'd0);
    check("arst zero", 32'(o_zero), 32'd0);
    check("arst illegal", 32'(o_illegal), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    check("arst ready", 32'(o_ready), 32'd1);
    for (int c = 0; c < 25; c++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      check("arst no stale", 32'(o_valid), 32'd0);
    end
    run_op("post rst", 4'b0001, 32'd1, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
